cr_intc: RTL and testbench
==========================

# cr_intc

Parametrised control-register and interrupt unit for the IOP core: holds PC, STATUS, IE, EPC, CPC, TEMP, CAUSE and a per-source vector table. It generalises the 4-source control-register block to NINT sources with latched pending bits, per-source edge/level mode, fixed priority and a readable cause register. It sits beside the decoder, which drives it with instruction-class strobes; the fetch and memory path consumes `pc_next` and `main_state`.

## Interface
- XLEN, 16, data and PC width
- NINT, 8, interrupt source count, 1..16
- EDGE_MASK, {NINT{1'b0}}, bit k=1: source k is rising-edge triggered, 0: level
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- int_in  in  NINT  interrupt request lines, synchronous to clk
- mem_read, mem_write  in  1  current instruction accesses memory
- mem_ok  in  1  memory access complete
- branch  in  1  branch taken; bra  in  1  branch-class instruction
- branch_offset  in  XLEN  branch offset
- ret, apc, jmp  in  1  return-from-interrupt, capture PC into CPC, register jump
- cr_addr  in  5  control-register index; cr_write  in  1  write strobe
- wdata  in  XLEN  write data (r6:r7 pair); rdata  out  XLEN  read data, combinational
- pc_next  out  XLEN  fetch address, combinational
- main_state  out  1  0=T0, 1=T1 (memory wait)
- int_ack  out  1  one-cycle pulse on interrupt acceptance; int_id  out  4  accepted source

## Operation
- Map: 0 STATUS{PGIE,GIE}, 1 IE[NINT-1:0], 2 EPC, 3 CPC, 4 IP (read; write-1-to-clear edge bits), 5 CAUSE{bit15 valid, [3:0] id}, 6 TEMP, 16+k TVECk (k<NINT). Unmapped: writes ignored, reads 0. Narrow fields zero-extended.
- Pending: level source IP[k]=int_in[k] live, W1C has no effect. Edge source: IP[k] set when int_in[k]=1 and its previous-cycle sample was 0; cleared by acceptance of k or W1C.
- eligible = IP & IE; int_acc = GIE & |eligible & !(bra|jmp|ret|mem_read|mem_write) & !main_state. Winner = lowest index in eligible.
- On int_acc: EPC<=PC, PC<=TVEC[winner]+1, PGIE<=GIE, GIE<=0, CAUSE<={1,winner}, IP[winner]<=0 if edge, int_ack=1, int_id=winner.
- ret: GIE<=PGIE, PC<=EPC+1. apc: CPC<=PC. jmp: PC<=wdata+1. branch: PC<=PC+branch_offset+1.
- Otherwise PC+=1 when (T0 & no memory access) or (T1 & mem_ok); else hold.
- pc_next = ret?EPC : branch?PC+branch_offset : jmp?wdata : PC.
- main_state: T0->T1 on mem_read|mem_write; T1->T0 on mem_ok.
- All PC arithmetic modulo 2^XLEN, wraps silently.

## Timing
- Reset: all registers 0, main_state 0, int_ack 0, int_id 0, edge history 0. A source held high through reset release does not create an edge.
- All state updates at posedge clk; acceptance visible in PC/EPC/STATUS the cycle after int_acc.
- int_ack/int_id combinational in the int_acc cycle; int_id is 0 when int_ack is 0.
- Priority: PC: int_acc > ret > jmp > branch > increment. GIE: rst|int_acc > ret > cr_write. PGIE: int_acc > cr_write. EPC: int_acc > cr_write. CPC: apc > cr_write.
- IP: new edge beats W1C and acceptance-clear in the same cycle (bit stays 1).
- CAUSE.valid cleared by writing 0 to CAUSE; acceptance overrides a simultaneous write.
- Write to IE/GIE affects eligibility from the next cycle.

## Structure
- Package cr_intc_pkg: register index constants, CAUSE field positions, default XLEN.
- Sub-module cr_intc_prio: NINT-wide fixed-priority encoder (valid, index).
- Top keeps TVEC as an NINT x XLEN array indexed by winner and by cr_addr-16.

## Test plan
- Reset, TVEC3=0x0200, IE=0x08, STATUS=1, edge source 3 pulsed at PC=0x0010 -> int_ack, int_id=3, PC=0x0201, EPC=0x0010, STATUS=0b10, CAUSE=0x8003, IP[3]=0.
- Sources 5 and 2 pending with both enabled -> id 2 taken; after ret, GIE=1, PC=EPC+1, source 5 accepted next.
- Interrupt asserted while mem_read in T0 and through T1 until mem_ok -> no acceptance until back in T0 with no access; then accepted.
- Level source held high after handler cleared GIE only -> no re-entry; W1C to its IP bit -> read still 1.
- Edge on source 1 same cycle as W1C IP=0x02 -> IP[1] reads 1.
- Branch at PC=0xFFFE offset 3 -> PC=0x0002, pc_next 0x0001 that cycle; read of index 9 returns 0.

Source files
------------

// File: rtl/cr_intc_pkg.sv
// Shared constants for the control-register / interrupt unit: register map,
// CAUSE field layout, default widths and the fetch/memory state encoding.
package cr_intc_pkg;

    localparam int XLEN_DEFAULT = 16;

    localparam logic [4:0] CR_STATUS = 5'd0;
    localparam logic [4:0] CR_IE     = 5'd1;
    localparam logic [4:0] CR_EPC    = 5'd2;
    localparam logic [4:0] CR_CPC    = 5'd3;
    localparam logic [4:0] CR_IP     = 5'd4;
    localparam logic [4:0] CR_CAUSE  = 5'd5;
    localparam logic [4:0] CR_TEMP   = 5'd6;

    localparam int CAUSE_VLD_BIT = 15;
    localparam int CAUSE_ID_W    = 4;

    typedef enum logic {
        ST_T0 = 1'b0,
        ST_T1 = 1'b1
    } main_state_t;

    // Vector table occupies indices 16..16+nint-1.
    function automatic logic is_tvec(input logic [4:0] addr, input int nint);
        return addr[4] && (int'(addr[3:0]) < nint);
    endfunction

endpackage

// File: rtl/cr_intc_prio.sv
// Fixed-priority encoder, lowest set index wins; purely combinational,
// zero latency, no flow control.
module cr_intc_prio #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         vld,
    output logic [3:0]   idx
);

    always_comb begin
        vld = |req;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = 4'(i);
        end
    end

endmodule

// File: rtl/cr_intc.sv
// Control registers, PC sequencing and NINT-source interrupt unit; state
// updates one cycle after strobes, rdata/pc_next/int_ack combinational, no stalls.
module cr_intc
    import cr_intc_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEFAULT,
    parameter int              NINT      = 8,
    parameter logic [NINT-1:0] EDGE_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NINT-1:0]   int_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_ok,
    input  logic              branch,
    input  logic              bra,
    input  logic [XLEN-1:0]   branch_offset,
    input  logic              ret,
    input  logic              apc,
    input  logic              jmp,
    input  logic [4:0]        cr_addr,
    input  logic              cr_write,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   pc_next,
    output logic              main_state,
    output logic              int_ack,
    output logic [3:0]        int_id
);

    localparam int              IW  = (NINT > 1) ? $clog2(NINT) : 1;
    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] pc, epc, cpc, temp;
    logic [XLEN-1:0] tvec [NINT];
    logic            gie, pgie;
    logic [NINT-1:0] ie, ip_edge, int_prev;
    logic            armed;
    logic            cause_vld;
    logic [3:0]      cause_id;
    main_state_t     state;

    logic            mem_acc;
    logic [NINT-1:0] new_edge, ip, eligible, acc_clr, w1c;
    logic            any_elig, int_acc;
    logic [3:0]      win_idx;
    logic            wr_status, wr_ie, wr_epc, wr_cpc, wr_ip, wr_cause, wr_temp, wr_tvec;
    logic            pc_step;

    assign mem_acc = mem_read | mem_write;

    // armed stays low for the first cycle after reset so a line already high
    // at release is absorbed into the history instead of firing.
    assign new_edge = armed ? (int_in & ~int_prev & EDGE_MASK) : '0;
    assign ip       = (ip_edge & EDGE_MASK) | (int_in & ~EDGE_MASK);
    assign eligible = ip & ie;

    cr_intc_prio #(.N(NINT)) u_prio (
        .req (eligible),
        .vld (any_elig),
        .idx (win_idx)
    );

    assign int_acc = gie & any_elig & ~(bra | jmp | ret | mem_acc) & (state == ST_T0);
    assign int_ack = int_acc;
    assign int_id  = int_acc ? win_idx : 4'd0;

    always_comb begin
        acc_clr = '0;
        for (int k = 0; k < NINT; k++) begin
            acc_clr[k] = int_acc && (win_idx == 4'(k));
        end
    end

    assign wr_status = cr_write && (cr_addr == CR_STATUS);
    assign wr_ie     = cr_write && (cr_addr == CR_IE);
    assign wr_epc    = cr_write && (cr_addr == CR_EPC);
    assign wr_cpc    = cr_write && (cr_addr == CR_CPC);
    assign wr_ip     = cr_write && (cr_addr == CR_IP);
    assign wr_cause  = cr_write && (cr_addr == CR_CAUSE);
    assign wr_temp   = cr_write && (cr_addr == CR_TEMP);
    assign wr_tvec   = cr_write && is_tvec(cr_addr, NINT);
    assign w1c       = wr_ip ? wdata[NINT-1:0] : '0;

    assign pc_step = ((state == ST_T0) && !mem_acc) || ((state == ST_T1) && mem_ok);

    assign pc_next = ret    ? epc :
                     branch ? pc + branch_offset :
                     jmp    ? wdata : pc;

    assign main_state = (state == ST_T1);

    always_comb begin
        rdata = '0;
        case (cr_addr)
            CR_STATUS: rdata[1:0] = {pgie, gie};
            CR_IE:     rdata[NINT-1:0] = ie;
            CR_EPC:    rdata = epc;
            CR_CPC:    rdata = cpc;
            CR_IP:     rdata[NINT-1:0] = ip;
            CR_CAUSE: begin
                rdata[CAUSE_VLD_BIT]    = cause_vld;
                rdata[CAUSE_ID_W-1:0]   = cause_id;
            end
            CR_TEMP:   rdata = temp;
            default: begin
                if (is_tvec(cr_addr, NINT)) rdata = tvec[cr_addr[IW-1:0]];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            epc       <= '0;
            cpc       <= '0;
            temp      <= '0;
            gie       <= 1'b0;
            pgie      <= 1'b0;
            ie        <= '0;
            ip_edge   <= '0;
            int_prev  <= '0;
            armed     <= 1'b0;
            cause_vld <= 1'b0;
            cause_id  <= '0;
            state     <= ST_T0;
            for (int k = 0; k < NINT; k++) tvec[k] <= '0;
        end else begin
            if (int_acc)      pc <= tvec[win_idx[IW-1:0]] + ONE;
            else if (ret)     pc <= epc + ONE;
            else if (jmp)     pc <= wdata + ONE;
            else if (branch)  pc <= pc + branch_offset + ONE;
            else if (pc_step) pc <= pc + ONE;

            if (int_acc)        gie <= 1'b0;
            else if (ret)       gie <= pgie;
            else if (wr_status) gie <= wdata[0];

            if (int_acc)        pgie <= gie;
            else if (wr_status) pgie <= wdata[1];

            if (int_acc)     epc <= pc;
            else if (wr_epc) epc <= wdata;

            if (apc)         cpc <= pc;
            else if (wr_cpc) cpc <= wdata;

            if (wr_ie)   ie   <= wdata[NINT-1:0];
            if (wr_temp) temp <= wdata;

            // A fresh edge wins over both clears in the same cycle.
            ip_edge  <= ((ip_edge & ~w1c & ~acc_clr) | new_edge) & EDGE_MASK;
            int_prev <= int_in;
            armed    <= 1'b1;

            if (int_acc) begin
                cause_vld <= 1'b1;
                cause_id  <= win_idx;
            end else if (wr_cause) begin
                cause_vld <= wdata[CAUSE_VLD_BIT];
                cause_id  <= wdata[CAUSE_ID_W-1:0];
            end

            if (wr_tvec) tvec[cr_addr[IW-1:0]] <= wdata;

            case (state)
                ST_T0: if (mem_acc) state <= ST_T1;
                ST_T1: if (mem_ok)  state <= ST_T0;
                default: state <= ST_T0;
            endcase
        end
    end

endmodule

// File: tb/tb_cr_intc.sv
// Randomized and directed bench for cr_intc against a cycle-level behavioural model.
module tb_cr_intc;

    localparam int        N  = 8;
    localparam bit [7:0]  EM = 8'b0000_1010;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  int_in;
    logic        mem_read, mem_write, mem_ok, branch, bra, ret, apc, jmp, cr_write;
    logic [15:0] branch_offset, wdata, rdata, pc_next;
    logic [4:0]  cr_addr;
    logic        main_state, int_ack;
    logic [3:0]  int_id;

    cr_intc #(.XLEN(16), .NINT(N), .EDGE_MASK(EM)) dut (
        .clk(clk), .rst(rst), .int_in(int_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ok(mem_ok),
        .branch(branch), .bra(bra), .branch_offset(branch_offset),
        .ret(ret), .apc(apc), .jmp(jmp),
        .cr_addr(cr_addr), .cr_write(cr_write), .wdata(wdata), .rdata(rdata),
        .pc_next(pc_next), .main_state(main_state),
        .int_ack(int_ack), .int_id(int_id)
    );

    always #5 clk = ~clk;

    int n_cmp, n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] m_pc, m_epc, m_cpc, m_temp;
    logic [15:0] m_tvec [N];
    bit          m_gie, m_pgie, m_cv, m_t1, m_armed;
    bit   [3:0]  m_cid;
    bit   [7:0]  m_ie, m_ipe, m_prev;

    bit          e_acc;
    int          e_win;
    logic [15:0] e_pcn, e_rd;
    logic [31:0] last_rdata, last_pcn, last_ack, last_id;

    task automatic model_reset();
        m_pc = 0; m_epc = 0; m_cpc = 0; m_temp = 0;
        for (int k = 0; k < N; k++) m_tvec[k] = 0;
        m_gie = 0; m_pgie = 0; m_cv = 0; m_cid = 0; m_t1 = 0; m_armed = 0;
        m_ie = 0; m_ipe = 0; m_prev = 0;
    endtask

    task automatic model_comb();
        bit [7:0] ip;
        int a;
        for (int k = 0; k < N; k++) ip[k] = EM[k] ? m_ipe[k] : int_in[k];
        e_win = -1;
        for (int k = 0; k < N; k++)
            if (e_win < 0 && ip[k] && m_ie[k]) e_win = k;
        e_acc = m_gie && (e_win >= 0) && !(bra || jmp || ret || mem_read || mem_write) && !m_t1;
        if (ret)         e_pcn = m_epc;
        else if (branch) e_pcn = m_pc + branch_offset;
        else if (jmp)    e_pcn = wdata;
        else             e_pcn = m_pc;
        a = int'(cr_addr);
        e_rd = 0;
        if (a == 0)      e_rd = {14'd0, m_pgie, m_gie};
        else if (a == 1) e_rd = {8'd0, m_ie};
        else if (a == 2) e_rd = m_epc;
        else if (a == 3) e_rd = m_cpc;
        else if (a == 4) e_rd = {8'd0, ip};
        else if (a == 5) e_rd = {m_cv, 11'd0, m_cid};
        else if (a == 6) e_rd = m_temp;
        else if (a >= 16 && a < 16 + N) e_rd = m_tvec[a - 16];
    endtask

    task automatic model_step();
        logic [15:0] n_pc, n_epc, n_cpc;
        bit          n_gie, n_pgie;
        bit   [7:0]  ne;
        int          a;
        bit          wr;
        a  = int'(cr_addr);
        wr = cr_write;
        for (int k = 0; k < N; k++) ne[k] = m_armed && EM[k] && int_in[k] && !m_prev[k];

        if (e_acc)       n_pc = m_tvec[e_win] + 16'd1;
        else if (ret)    n_pc = m_epc + 16'd1;
        else if (jmp)    n_pc = wdata + 16'd1;
        else if (branch) n_pc = m_pc + branch_offset + 16'd1;
        else if ((!m_t1 && !(mem_read || mem_write)) || (m_t1 && mem_ok)) n_pc = m_pc + 16'd1;
        else             n_pc = m_pc;

        n_gie  = e_acc ? 1'b0 : ret ? m_pgie : (wr && a == 0) ? wdata[0] : m_gie;
        n_pgie = e_acc ? m_gie : (wr && a == 0) ? wdata[1] : m_pgie;
        n_epc  = e_acc ? m_pc : (wr && a == 2) ? wdata : m_epc;
        n_cpc  = apc ? m_pc : (wr && a == 3) ? wdata : m_cpc;

        for (int k = 0; k < N; k++) begin
            if (ne[k]) m_ipe[k] = 1;
            else if (wr && a == 4 && wdata[k]) m_ipe[k] = 0;
            else if (e_acc && e_win == k) m_ipe[k] = 0;
        end
        if (e_acc) begin
            m_cv = 1; m_cid = 4'(e_win);
        end else if (wr && a == 5) begin
            m_cv = wdata[15]; m_cid = wdata[3:0];
        end
        if (wr && a == 1) m_ie = wdata[7:0];
        if (wr && a == 6) m_temp = wdata;
        if (wr && a >= 16 && a < 16 + N) m_tvec[a - 16] = wdata;
        m_t1    = m_t1 ? !mem_ok : (mem_read || mem_write);
        m_prev  = int_in;
        m_armed = 1;
        m_pc = n_pc; m_epc = n_epc; m_cpc = n_cpc; m_gie = n_gie; m_pgie = n_pgie;
    endtask

    task automatic cycle();
        #1;
        model_comb();
        chk("int_ack", int_ack, e_acc);
        chk("int_id", int_id, e_acc ? e_win : 0);
        chk("pc_next", pc_next, e_pcn);
        chk("rdata", rdata, e_rd);
        chk("main_state", main_state, m_t1);
        last_rdata = rdata; last_pcn = pc_next; last_ack = int_ack; last_id = int_id;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr();
        mem_read = 0; mem_write = 0; mem_ok = 0; branch = 0; bra = 0;
        ret = 0; apc = 0; jmp = 0; cr_write = 0; cr_addr = 0;
        wdata = 0; branch_offset = 0;
    endtask

    task automatic idle();
        clr(); cycle();
    endtask

    task automatic rd(input logic [4:0] a);
        clr(); cr_addr = a; cycle();
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        clr(); cr_write = 1; cr_addr = a; wdata = d; cycle();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        clr();
        int_in = 8'h08;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        model_reset();

        // Edge source held high across reset release must not latch.
        rd(5'd4); rd(5'd4);
        chk("no_edge_from_reset", last_rdata, 0);
        int_in = 0;
        rd(5'd0); rd(5'd1); rd(5'd2); rd(5'd3); rd(5'd5); rd(5'd6);

        // Basic acceptance of edge source 3.
        wr(5'd19, 16'h0200); wr(5'd1, 16'h0008); wr(5'd0, 16'h0001);
        for (int i = 0; i < 64 && m_pc != 16'h000F; i++) idle();
        int_in = 8'h08; idle();
        int_in = 8'h00; idle();
        chk("acc_ack", last_ack, 1);
        chk("acc_id", last_id, 3);
        rd(5'd2);
        chk("epc", last_rdata, 16'h0010);
        chk("pc_after_acc", last_pcn, 16'h0201);
        rd(5'd0); chk("status_after_acc", last_rdata, 2);
        rd(5'd5); chk("cause", last_rdata, 16'h8003);
        rd(5'd4); chk("ip_cleared", last_rdata, 0);

        // Priority: 2 beats 5; ret re-enables and 5 follows.
        wr(5'd1, 16'h0024);
        int_in = 8'h24;
        wr(5'd0, 16'h0001);
        idle();
        chk("prio_ack", last_ack, 1);
        chk("prio_id", last_id, 2);
        int_in = 8'h20;
        clr(); ret = 1; cycle();
        chk("ret_blocks_acc", last_ack, 0);
        rd(5'd0);
        chk("gie_after_ret", last_rdata & 32'd1, 1);
        chk("second_id", last_id, 5);

        // Level source with GIE cleared: no re-entry, W1C ignored.
        int_in = 8'h01;
        wr(5'd1, 16'h0001);
        idle();
        chk("level_no_reentry", last_ack, 0);
        wr(5'd4, 16'h0001);
        rd(5'd4);
        chk("level_w1c_ignored", last_rdata & 32'd1, 1);

        // New edge on source 1 wins over same-cycle W1C.
        int_in = 8'h00; idle();
        int_in = 8'h02;
        wr(5'd4, 16'h0002);
        rd(5'd4);
        chk("edge_beats_w1c", (last_rdata >> 1) & 32'd1, 1);
        int_in = 8'h00;
        wr(5'd4, 16'h0002);
        rd(5'd4);
        chk("w1c_clears", (last_rdata >> 1) & 32'd1, 0);

        // PC wrap on branch and unmapped read.
        clr(); jmp = 1; wdata = 16'hFFFD; cycle();
        clr(); bra = 1; branch = 1; branch_offset = 16'd3; cr_addr = 5'd9; cycle();
        chk("wrap_pc_next", last_pcn, 16'h0001);
        chk("unmapped_read", last_rdata, 0);
        idle();
        chk("wrap_pc", last_pcn, 16'h0002);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic mr, mw;
            int   r;
            mr = mem_read; mw = mem_write;
            clr();
            if (m_t1) begin
                mem_read = mr; mem_write = mw;
            end else begin
                r = $urandom_range(0, 15);
                case (r)
                    0: mem_read = 1;
                    1: mem_write = 1;
                    2: begin bra = 1; branch = 1'($urandom_range(0, 1)); end
                    3: jmp = 1;
                    4: ret = 1;
                    5: apc = 1;
                    default: ;
                endcase
            end
            mem_ok        = ($urandom_range(0, 2) == 0);
            branch_offset = 16'($urandom);
            wdata         = 16'($urandom);
            cr_write      = ($urandom_range(0, 2) == 0);
            cr_addr       = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 6))
                                                        : 5'($urandom_range(0, 31));
            for (int k = 0; k < N; k++) begin
                if (EM[k]) begin
                    if ($urandom_range(0, 3) == 0) int_in[k] = ~int_in[k];
                end else begin
                    int_in[k] = ($urandom_range(0, 7) == 0);
                end
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
